// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one dual-port frame SRAM (one write port, one read port) between
// three agents of forward_transform_soc:
//   - capture path : write only, never stalled, highest write priority
//   - transform    : reads and writes (valid/ready handshakes)
//   - AHB host     : reads only (valid/ready handshake)
//
// Write port : fixed priority, capture over transform.
// Read port  : round-robin between transform and host.
// All SRAM strobes are registered. Returned read data is steered to the agent
// that issued the read by an owner/valid pipeline matching the SRAM latency.
//
// Ports
//   in_HCLK, in_HRESET                       clock, synchronous active-high reset
//   in_cap_we/addr/data                      capture write (always accepted)
//   in_xf_wvalid/waddr/wdata, out_xf_wready  transform write handshake
//   in_xf_rvalid/raddr, out_xf_rready        transform read request handshake
//   out_xf_rdvalid/rdata                     transform read return
//   in_host_rvalid/raddr, out_host_rready    host read request handshake
//   out_host_rdvalid/rdata                   host read return
//   out_SRAM_we/w_ADDR/w_DATA                registered SRAM write port
//   out_SRAM_re/r_ADDR, in_SRAM_r_DATA       registered SRAM read port, read data
//   in_cnt_clr, out_xf_wstall_cnt            saturating transform-write stall counter
//
// Read timing: in_SRAM_r_DATA is sampled RD_LAT rising edges after the edge
// that raised out_SRAM_re, so a read accepted at edge N returns rdvalid/rdata
// in cycle N+1+RD_LAT.
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              in_HCLK,
    input  logic              in_HRESET,

    input  logic              in_cap_we,
    input  logic [ADDR_W-1:0] in_cap_addr,
    input  logic [DATA_W-1:0] in_cap_data,

    input  logic              in_xf_wvalid,
    input  logic [ADDR_W-1:0] in_xf_waddr,
    input  logic [DATA_W-1:0] in_xf_wdata,
    output logic              out_xf_wready,

    input  logic              in_xf_rvalid,
    input  logic [ADDR_W-1:0] in_xf_raddr,
    output logic              out_xf_rready,
    output logic              out_xf_rdvalid,
    output logic [DATA_W-1:0] out_xf_rdata,

    input  logic              in_host_rvalid,
    input  logic [ADDR_W-1:0] in_host_raddr,
    output logic              out_host_rready,
    output logic              out_host_rdvalid,
    output logic [DATA_W-1:0] out_host_rdata,

    input  logic [DATA_W-1:0] in_SRAM_r_DATA,
    output logic              out_SRAM_we,
    output logic              out_SRAM_re,
    output logic [ADDR_W-1:0] out_SRAM_w_ADDR,
    output logic [ADDR_W-1:0] out_SRAM_r_ADDR,
    output logic [DATA_W-1:0] out_SRAM_w_DATA,

    input  logic              in_cnt_clr,
    output logic [15:0]       out_xf_wstall_cnt
);

    typedef enum logic {
        OWN_XF   = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    owner_e            last;                     // most recently granted reader
    logic              grant_xf;
    logic              grant_host;
    logic [RD_LAT-1:0] pipe_valid;
    owner_e            pipe_owner [RD_LAT];
    logic              tail_xf;
    logic              tail_host;

    // -------------------------------------------------------------------------
    // Write port: capture always wins. Handshakes are held low while reset is
    // being sampled so no agent sees an acceptance the registers will discard.
    // -------------------------------------------------------------------------
    assign out_xf_wready = in_xf_wvalid & ~in_cap_we & ~in_HRESET;

    always_ff @(posedge in_HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (in_HRESET) begin
            out_SRAM_we     <= 1'b0;
            out_SRAM_w_ADDR <= '0;
            out_SRAM_w_DATA <= '0;
        end else if (in_cap_we) begin
            out_SRAM_we     <= 1'b1;
            out_SRAM_w_ADDR <= in_cap_addr;
            out_SRAM_w_DATA <= in_cap_data;
        end else if (in_xf_wvalid) begin
            out_SRAM_we     <= 1'b1;
            out_SRAM_w_ADDR <= in_xf_waddr;
            out_SRAM_w_DATA <= in_xf_wdata;
        end else begin
            out_SRAM_we     <= 1'b0;            // address and data hold
        end
    end

    // -------------------------------------------------------------------------
    // Read port: round-robin. Under contention the reader that was not granted
    // last time wins; a lone requester always wins.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch
        // is inferred.
        grant_xf   = 1'b0;
        grant_host = 1'b0;
        if (!in_HRESET) begin
            if (in_xf_rvalid && (!in_host_rvalid || last == OWN_HOST)) begin
                grant_xf = 1'b1;
            end else if (in_host_rvalid) begin
                grant_host = 1'b1;
            end
        end
    end

    assign out_xf_rready   = grant_xf;
    assign out_host_rready = grant_host;

    always_ff @(posedge in_HCLK) begin
        if (in_HRESET) begin
            last            <= OWN_HOST;        // transform wins first contention
            out_SRAM_re     <= 1'b0;
            out_SRAM_r_ADDR <= '0;
        end else if (grant_xf) begin
            last            <= OWN_XF;
            out_SRAM_re     <= 1'b1;
            out_SRAM_r_ADDR <= in_xf_raddr;
        end else if (grant_host) begin
            last            <= OWN_HOST;
            out_SRAM_re     <= 1'b1;
            out_SRAM_r_ADDR <= in_host_raddr;
        end else begin
            out_SRAM_re     <= 1'b0;            // address holds
        end
    end

    // -------------------------------------------------------------------------
    // Return routing: stage 0 loads alongside out_SRAM_re; the tail stage
    // coincides with valid SRAM read data, which is captured into the owner's
    // output register (the final pipeline stage). Reset empties the pipeline so
    // reads granted before reset never return.
    // -------------------------------------------------------------------------
    assign tail_xf   = pipe_valid[RD_LAT-1] && (pipe_owner[RD_LAT-1] == OWN_XF);
    assign tail_host = pipe_valid[RD_LAT-1] && (pipe_owner[RD_LAT-1] == OWN_HOST);

    always_ff @(posedge in_HCLK) begin
        if (in_HRESET) begin
            pipe_valid       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_owner[i] <= OWN_XF;
            end
            out_xf_rdvalid   <= 1'b0;
            out_host_rdvalid <= 1'b0;
            out_xf_rdata     <= '0;
            out_host_rdata   <= '0;
        end else begin
            pipe_valid[0] <= grant_xf | grant_host;
            pipe_owner[0] <= grant_host ? OWN_HOST : OWN_XF;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end

            out_xf_rdvalid   <= tail_xf;
            out_host_rdvalid <= tail_host;
            if (tail_xf) begin
                out_xf_rdata <= in_SRAM_r_DATA;
            end
            if (tail_host) begin
                out_host_rdata <= in_SRAM_r_DATA;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: cycles in which a transform write lost to capture.
    // Clear beats increment; the count sticks at all-ones.
    // -------------------------------------------------------------------------
    always_ff @(posedge in_HCLK) begin
        if (in_HRESET || in_cnt_clr) begin
            out_xf_wstall_cnt <= '0;
        end else if (in_xf_wvalid && in_cap_we && (out_xf_wstall_cnt != 16'hFFFF)) begin
            out_xf_wstall_cnt <= out_xf_wstall_cnt + 16'd1;
        end
    end

endmodule
